// File: rtl/cla_mp_sequencer.sv
// cla_mp_sequencer: multi-precision add/sub that time-shares one 8-bit CLA,
// processing one byte per clock LSB first with a registered inter-byte carry.
module cla8_adder (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);
   logic [7:0] g, p;
   logic [8:0] c;
   always_comb begin
      g = a & b;
      p = a ^ b;
      c = '0;
      c[0] = cin;
      for (int k = 0; k < 8; k++) c[k+1] = g[k] | (p[k] & c[k]);
      sum = p ^ c[7:0];
      cout = c[8];
   end
endmodule

module cla_mp_sequencer #(
   parameter int NBYTES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [8*NBYTES-1:0] op_a,
   input  logic [8*NBYTES-1:0] op_b,
   input  logic              op_sub,
   input  logic              cin_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [8*NBYTES-1:0] result,
   output logic              cout,
   output logic              ovf,
   output logic              busy
);
   localparam int W = 8 * NBYTES;
   localparam int IW = $clog2(NBYTES);

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t state, state_nx;
   logic [W-1:0] a_q, b_q;
   logic sub_q, carry_q;
   logic [IW-1:0] idx;
   logic [7:0] a_byte, b_byte, sum_byte;
   logic co, last;

   assign a_byte = a_q[{idx, 3'b000} +: 8];
   assign b_byte = b_q[{idx, 3'b000} +: 8] ^ {8{sub_q}};
   assign last = idx == IW'(NBYTES - 1);

   cla8_adder u_add (
      .a(a_byte),
      .b(b_byte),
      .cin(carry_q),
      .sum(sum_byte),
      .cout(co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: state_nx = in_valid ? RUN : IDLE;
         RUN: state_nx = last ? HOLD : RUN;
         HOLD: state_nx = out_ready ? IDLE : HOLD;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready = state == IDLE;
      busy = state == RUN;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
         sub_q <= 1'b0;
         carry_q <= 1'b0;
         idx <= '0;
         result <= '0;
         cout <= 1'b0;
         ovf <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_q <= op_a;
               b_q <= op_b;
               sub_q <= op_sub;
               carry_q <= op_sub | cin_in;
               idx <= '0;
               result <= '0;
            end
            RUN: begin
               result[{idx, 3'b000} +: 8] <= sum_byte;
               carry_q <= co;
               idx <= last ? '0 : idx + 1'b1;
               if (last) begin
                  cout <= co;
                  ovf <= (a_byte[7] == b_byte[7]) && (sum_byte[7] != a_byte[7]);
                  out_valid <= 1'b1;
               end
            end
            HOLD: if (out_ready) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule
